// File: rtl/sound_generator.sv
// sound_generator
//
// Turns Snake gameplay events into a fixed-length square-wave tone on an
// 8-bit DAC sample bus. Each event (bad collision, apple eaten, direction
// change) selects its own half-period. A higher or equal priority event
// restarts the tone. A lower priority event is dropped while a tone plays.
//
// Optional feature macro: SOUND_GEN_MUTE_EN
//   defined   - a rising edge on button_i toggles mute. While muted, events
//               are ignored and the output is silent. Muting during a tone
//               ends the tone immediately.
//   undefined - button_i is ignored and the block is never muted.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous active-high reset
//   button_i     mute-toggle button level
//   goodColl_i   good collision level (apple eaten)
//   badColl_i    bad collision level (wall / self)
//   direction_i  current snake direction code, 0 = none
//   soundOut     DAC sample: AMPLITUDE during the high half of the wave, else 0

module sound_generator #(
  parameter int          GOOD_HALF = 8,
  parameter int          BAD_HALF  = 20,
  parameter int          MOVE_HALF = 4,
  parameter int          DURATION  = 512,
  parameter logic [7:0]  AMPLITUDE = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic [3:0] direction_i,
  output logic [7:0] soundOut
);

  // The encoding doubles as the priority. A plain numeric compare then
  // decides whether a trigger may preempt the current tone. IDLE (0) is
  // always preempted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    GOOD = 2'd2,
    BAD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic        muted_q, muted_d;
  logic [15:0] dur_cnt_q, dur_cnt_d;
  logic [15:0] tone_cnt_q, tone_cnt_d;
  logic        prev_good_q, prev_good_d;
  logic        prev_bad_q, prev_bad_d;
  logic [3:0]  prev_dir_q, prev_dir_d;

  logic        good_trig, bad_trig, move_trig;
  logic        trig_valid;
  state_e      trig_state;
  logic [15:0] half_sel;
  logic        mute_now;

`ifdef SOUND_GEN_MUTE_EN
  logic prev_button_q, prev_button_d;
`else
  logic unused_button;
  assign unused_button = button_i;
`endif

  always_comb begin
    good_trig = goodColl_i & ~prev_good_q;
    bad_trig  = badColl_i & ~prev_bad_q;
    move_trig = (direction_i != prev_dir_q) && (direction_i != 4'd0);

    if (bad_trig)       trig_state = BAD;
    else if (good_trig) trig_state = GOOD;
    else if (move_trig) trig_state = MOVE;
    else                trig_state = IDLE;

    trig_valid = (trig_state != IDLE) && !muted_q;

    case (state_q)
      BAD:     half_sel = 16'(BAD_HALF);
      MOVE:    half_sel = 16'(MOVE_HALF);
      default: half_sel = 16'(GOOD_HALF);
    endcase

    state_d     = state_q;
    phase_d     = phase_q;
    dur_cnt_d   = dur_cnt_q;
    tone_cnt_d  = tone_cnt_q;
    prev_good_d = goodColl_i;
    prev_bad_d  = badColl_i;
    prev_dir_d  = direction_i;

`ifdef SOUND_GEN_MUTE_EN
    prev_button_d = button_i;
    muted_d       = (button_i && !prev_button_q) ? !muted_q : muted_q;
    // Only the unmuted-to-muted transition cuts a tone short.
    mute_now      = button_i && !prev_button_q && !muted_q;
`else
    muted_d  = 1'b0;
    mute_now = 1'b0;
`endif

    if (mute_now) begin
      state_d    = IDLE;
      phase_d    = 1'b0;
      dur_cnt_d  = 16'd0;
      tone_cnt_d = 16'd0;
    end else if (trig_valid && (trig_state >= state_q)) begin
      state_d    = trig_state;
      phase_d    = 1'b1;
      dur_cnt_d  = 16'd0;
      tone_cnt_d = 16'd0;
    end else if (state_q != IDLE) begin
      // Reaching the end of the duration takes precedence over a phase toggle.
      if (dur_cnt_q == 16'(DURATION - 1)) begin
        state_d    = IDLE;
        phase_d    = 1'b0;
        dur_cnt_d  = 16'd0;
        tone_cnt_d = 16'd0;
      end else begin
        dur_cnt_d = dur_cnt_q + 16'd1;
        if (tone_cnt_q == half_sel - 16'd1) begin
          phase_d    = !phase_q;
          tone_cnt_d = 16'd0;
        end else begin
          tone_cnt_d = tone_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      muted_q       <= 1'b0;
      dur_cnt_q     <= 16'd0;
      tone_cnt_q    <= 16'd0;
      prev_good_q   <= 1'b0;
      prev_bad_q    <= 1'b0;
      prev_dir_q    <= 4'd0;
`ifdef SOUND_GEN_MUTE_EN
      prev_button_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      muted_q       <= muted_d;
      dur_cnt_q     <= dur_cnt_d;
      tone_cnt_q    <= tone_cnt_d;
      prev_good_q   <= prev_good_d;
      prev_bad_q    <= prev_bad_d;
      prev_dir_q    <= prev_dir_d;
`ifdef SOUND_GEN_MUTE_EN
      prev_button_q <= prev_button_d;
`endif
    end
  end

  // Derived only from registers. An asynchronous reset therefore silences
  // the output at once.
  assign soundOut = ((state_q != IDLE) && phase_q && !muted_q) ? AMPLITUDE : 8'd0;

endmodule

// File: tb/tb_sound_generator.sv
// tb_sound_generator
//
// Directed testbench for sound_generator with the default parameters.
// Inputs change on the falling clock edge. soundOut is sampled on the
// falling edge, half a cycle after the rising edge it reflects. Sample i of
// a tone is taken after the rising edge that is i cycles past the
// triggering edge.

module tb_sound_generator;

  localparam int         GH  = 8;
  localparam int         BH  = 20;
  localparam int         MH  = 4;
  localparam int         DUR = 512;
  localparam logic [7:0] AMP = 8'd128;

`ifdef SOUND_GEN_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       button_i;
  logic       goodColl_i;
  logic       badColl_i;
  logic [3:0] direction_i;
  logic [7:0] soundOut;

  int total_cnt = 0;
  int bad_cnt   = 0;

  sound_generator #(
    .GOOD_HALF (GH),
    .BAD_HALF  (BH),
    .MOVE_HALF (MH),
    .DURATION  (DUR),
    .AMPLITUDE (AMP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_i    (button_i),
    .goodColl_i  (goodColl_i),
    .badColl_i   (badColl_i),
    .direction_i (direction_i),
    .soundOut    (soundOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected sample i cycles after a tone starts with half-period `half`.
  function automatic logic [7:0] tone_exp(input int i, input int half);
    if (i < DUR && ((i / half) % 2) == 0) return AMP;
    return 8'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; button_i = 1'b0; goodColl_i = 1'b0; badColl_i = 1'b0; direction_i = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== 8'd0) begin
        bad_cnt++;
        $display("FAIL reset_hold cyc=%0d got=%0d want=0", i, soundOut);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== 8'd0) begin
        bad_cnt++;
        $display("FAIL reset_release cyc=%0d got=%0d want=0", i, soundOut);
      end
    end
  endtask

  task automatic test_good_tone();
    goodColl_i = 1'b1;
    for (int i = 0; i < DUR + 20; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, GH)) begin
        bad_cnt++;
        $display("FAIL good_tone cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, GH));
      end
      if (i == 4) goodColl_i = 1'b0;
    end
  endtask

  task automatic test_bad_preempts_good();
    goodColl_i = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, GH)) begin
        bad_cnt++;
        $display("FAIL preempt_good_part cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, GH));
      end
      if (i == 0) goodColl_i = 1'b0;
    end
    badColl_i = 1'b1;
    for (int j = 0; j < DUR + 20; j++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(j, BH)) begin
        bad_cnt++;
        $display("FAIL preempt_bad_part cyc=%0d got=%0d want=%0d", j, soundOut, tone_exp(j, BH));
      end
      if (j == 0) badColl_i = 1'b0;
    end
  endtask

  task automatic test_direction();
    direction_i = 4'b0001;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, MH)) begin
        bad_cnt++;
        $display("FAIL direction_tone cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, MH));
      end
    end
    direction_i = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== 8'd0) begin
        bad_cnt++;
        $display("FAIL direction_zero cyc=%0d got=%0d want=0", i, soundOut);
      end
    end
  endtask

  // A direction change during a good tone has lower priority and is dropped.
  task automatic test_move_dropped();
    goodColl_i = 1'b1;
    for (int i = 0; i < DUR + 20; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, GH)) begin
        bad_cnt++;
        $display("FAIL move_dropped cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, GH));
      end
      if (i == 0) goodColl_i = 1'b0;
      if (i == 10) direction_i = 4'b0010;
    end
    direction_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_mute();
    logic [7:0] want;
    // A mute-toggle pulse, then a good event. Silent only when mute exists.
    button_i = 1'b1;
    @(negedge clk);
    button_i = 1'b0;
    goodColl_i = 1'b1;
    for (int i = 0; i < DUR + 10; i++) begin
      @(negedge clk);
      want = MUTE_EN ? 8'd0 : tone_exp(i, GH);
      total_cnt++;
      if (soundOut !== want) begin
        bad_cnt++;
        $display("FAIL mute_on cyc=%0d got=%0d want=%0d", i, soundOut, want);
      end
      if (i == 0) goodColl_i = 1'b0;
    end
    // Toggle back, then a good event plays in both builds.
    button_i = 1'b1;
    @(negedge clk);
    button_i = 1'b0;
    goodColl_i = 1'b1;
    for (int i = 0; i < DUR + 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, GH)) begin
        bad_cnt++;
        $display("FAIL mute_off cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, GH));
      end
      if (i == 0) goodColl_i = 1'b0;
    end
    // Muting in the middle of a tone cuts it off at that edge.
    goodColl_i = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, GH)) begin
        bad_cnt++;
        $display("FAIL midmute_pre cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, GH));
      end
      if (i == 0) goodColl_i = 1'b0;
    end
    button_i = 1'b1;
    for (int j = 0; j < DUR; j++) begin
      @(negedge clk);
      want = MUTE_EN ? 8'd0 : tone_exp(21 + j, GH);
      total_cnt++;
      if (soundOut !== want) begin
        bad_cnt++;
        $display("FAIL midmute_post cyc=%0d got=%0d want=%0d", j, soundOut, want);
      end
      if (j == 0) button_i = 1'b0;
    end
    // Leave the block unmuted for the following tests.
    button_i = 1'b1;
    @(negedge clk);
    button_i = 1'b0;
    @(negedge clk);
    if (!MUTE_EN) begin
      button_i = 1'b1;
      @(negedge clk);
      button_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    goodColl_i = 1'b1;
    badColl_i  = 1'b1;
    for (int i = 0; i < DUR + 20; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, BH)) begin
        bad_cnt++;
        $display("FAIL simultaneous cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, BH));
      end
      if (i == 0) begin
        goodColl_i = 1'b0;
        badColl_i  = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    goodColl_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== tone_exp(i, GH)) begin
        bad_cnt++;
        $display("FAIL areset_pre cyc=%0d got=%0d want=%0d", i, soundOut, tone_exp(i, GH));
      end
      if (i == 0) goodColl_i = 1'b0;
    end
    // Assert reset between clock edges; the output must drop without a clock.
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (soundOut !== 8'd0) begin
      bad_cnt++;
      $display("FAIL areset_immediate got=%0d want=0", soundOut);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== 8'd0) begin
        bad_cnt++;
        $display("FAIL areset_hold cyc=%0d got=%0d want=0", i, soundOut);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (soundOut !== 8'd0) begin
        bad_cnt++;
        $display("FAIL areset_release cyc=%0d got=%0d want=0", i, soundOut);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_tone();
    test_bad_preempts_good();
    test_direction();
    test_move_dropped();
    test_mute();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
